// File: rtl/fetch_ctrl_if.sv
// Instruction-memory fetch channel between the fetch controller and imem.
// The controller holds imem_req until imem_ack returns the word.
interface fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// P5 MIPS fetch controller: PC register, imem handshake and IF/ID register.
// Redirects resolved in D apply after the delay-slot instruction is delivered.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic           clk,
    input  logic           reset,
    fetch_ctrl_if.master   imem,
    input  logic           stall,
    input  logic           br_valid,
    input  logic [2:0]     br_sel,
    input  logic [31:0]    br_pc,
    input  logic [31:0]    br_imm32,
    input  logic [31:0]    br_reg,
    input  logic [25:0]    br_imm26,
    output logic [31:0]    pc,
    output logic [31:0]    if_id_instr,
    output logic [31:0]    if_id_pc,
    output logic           if_id_valid
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] buf_q;
    logic [31:0] redir_pc_q;
    logic        redir_pending_q;

    logic        deliver;
    logic        latch;
    logic        bubble;
    logic        br_take;
    logic [31:0] p4;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic [31:0] word;

    assign pc             = pc_q;
    assign imem.imem_addr = pc_q;

    // Redirect target from the D-stage control-transfer fields.
    always_comb begin
        p4      = br_pc + 32'd4;
        target  = p4 + 32'd4;
        br_take = 1'b0;
        case (br_sel)
            3'd1: begin
                target  = p4 + (br_imm32 << 2);
                br_take = br_valid && !stall;
            end
            3'd2: begin
                target  = br_reg;
                br_take = br_valid && !stall;
            end
            3'd3: begin
                target  = {p4[31:28], br_imm26, 2'b00};
                br_take = br_valid && !stall;
            end
            default: begin
                target  = p4 + 32'd4;
                br_take = 1'b0;
            end
        endcase
    end

    // Next-state, request and delivery decisions.
    always_comb begin
        state_d       = state_q;
        imem.imem_req = 1'b0;
        deliver       = 1'b0;
        latch         = 1'b0;
        bubble        = 1'b0;
        case (state_q)
            FETCH: begin
                imem.imem_req = !reset;
                if (imem.imem_ack && !stall) begin
                    deliver = 1'b1;
                end else if (imem.imem_ack && stall) begin
                    latch   = 1'b1;
                    state_d = HOLD;
                end else if (!stall) begin
                    bubble  = 1'b1;
                end
            end
            HOLD: begin
                if (!stall) begin
                    deliver = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Delivered word and the PC that follows it.
    always_comb begin
        word = (state_q == HOLD) ? buf_q : imem.imem_rdata;
        if (br_take) begin
            next_pc = target;
        end else if (redir_pending_q) begin
            next_pc = redir_pc_q;
        end else begin
            next_pc = pc_q + 32'd4;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, hold buffer, pending redirect and IF/ID register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q            <= RESET_PC;
            buf_q           <= 32'd0;
            redir_pc_q      <= 32'd0;
            redir_pending_q <= 1'b0;
            if_id_instr     <= 32'd0;
            if_id_pc        <= 32'd0;
            if_id_valid     <= 1'b0;
        end else begin
            if (deliver) begin
                if_id_instr     <= word;
                if_id_pc        <= pc_q;
                if_id_valid     <= 1'b1;
                pc_q            <= next_pc;
                redir_pending_q <= 1'b0;
            end else begin
                if (br_take) begin
                    redir_pc_q      <= target;
                    redir_pending_q <= 1'b1;
                end
                if (bubble) begin
                    if_id_valid <= 1'b0;
                end
            end
            if (latch) begin
                buf_q <= imem.imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then randomized traffic,
// checked against a behavioural model of the fetch rules.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [2:0]  br_sel = 3'd0;
    logic [31:0] br_pc = 32'd0;
    logic [31:0] br_imm32 = 32'd0;
    logic [31:0] br_reg = 32'd0;
    logic [25:0] br_imm26 = 26'd0;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;

    fetch_ctrl_if u_if ();

    fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem       (u_if),
        .stall      (stall),
        .br_valid   (br_valid),
        .br_sel     (br_sel),
        .br_pc      (br_pc),
        .br_imm32   (br_imm32),
        .br_reg     (br_reg),
        .br_imm26   (br_imm26),
        .pc         (pc),
        .if_id_instr(if_id_instr),
        .if_id_pc   (if_id_pc),
        .if_id_valid(if_id_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: fetch address, a word waiting for the stall to
    // clear, an outstanding redirect, and the IF/ID contents.
    logic [31:0] m_pc;
    logic        m_have_word;
    logic [31:0] m_word;
    logic        m_redir;
    logic [31:0] m_redir_pc;
    logic [31:0] m_ifi;
    logic [31:0] m_ifp;
    logic        m_ifv;

    task automatic model_reset();
        m_pc        = 32'h3000;
        m_have_word = 1'b0;
        m_word      = 32'd0;
        m_redir     = 1'b0;
        m_redir_pc  = 32'd0;
        m_ifi       = 32'd0;
        m_ifp       = 32'd0;
        m_ifv       = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_target();
        logic [31:0] t;
        t = 32'd0;
        if (br_sel == 3'd1) t = br_pc + 32'd4 + br_imm32 * 32'd4;
        if (br_sel == 3'd2) t = br_reg;
        if (br_sel == 3'd3)
            t = ((br_pc + 32'd4) & 32'hF000_0000) | ({6'd0, br_imm26} * 32'd4);
        return t;
    endfunction

    // Advance the model across one clock edge using the driven inputs.
    task automatic model_step();
        logic taken;
        logic avail;
        logic [31:0] w;
        if (reset) begin
            model_reset();
            return;
        end
        taken = br_valid && !stall && br_sel >= 3'd1 && br_sel <= 3'd3;
        avail = m_have_word || u_if.imem_ack;
        w = m_have_word ? m_word : u_if.imem_rdata;
        if (avail && !stall) begin
            m_ifi = w;
            m_ifp = m_pc;
            m_ifv = 1'b1;
            if (taken) m_pc = model_target();
            else if (m_redir) m_pc = m_redir_pc;
            else m_pc = m_pc + 32'd4;
            m_redir = 1'b0;
            m_have_word = 1'b0;
        end else begin
            if (taken) begin
                m_redir_pc = model_target();
                m_redir = 1'b1;
            end
            if (avail && stall && !m_have_word) begin
                m_have_word = 1'b1;
                m_word = u_if.imem_rdata;
            end
            if (!stall) m_ifv = 1'b0;
        end
    endtask

    // One clock: drive at posedge+1, check combinational outputs, then
    // registered outputs just after the next edge.
    task automatic tick(input logic r, input logic s, input logic a,
                        input logic bv, input logic [2:0] bs,
                        input logic [31:0] bpc, input logic [31:0] bimm,
                        input logic [31:0] breg, input logic [25:0] bi26);
        logic exp_req;
        reset = r;
        stall = s;
        br_valid = bv;
        br_sel = bs;
        br_pc = bpc;
        br_imm32 = bimm;
        br_reg = breg;
        br_imm26 = bi26;
        u_if.imem_rdata = $urandom;
        #1;
        u_if.imem_ack = a && u_if.imem_req;
        #1;
        exp_req = !r && !m_have_word;
        chk("imem_req", {31'd0, u_if.imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", u_if.imem_addr, m_pc);
        @(posedge clk);
        model_step();
        #1;
        chk("pc", pc, m_pc);
        chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_ifv});
        chk("if_id_pc", if_id_pc, m_ifp);
        chk("if_id_instr", if_id_instr, m_ifi);
    endtask

    task automatic cyc(input logic r, input logic s, input logic a);
        tick(r, s, a, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 26'd0);
    endtask

    initial begin
        u_if.imem_ack = 1'b0;
        u_if.imem_rdata = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Zero-wait imem streams one instruction per cycle.
        cyc(1, 0, 0);
        chk("rst_pc", pc, 32'h3000);
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        cyc(0, 0, 1);
        chk("t1_ifpc0", if_id_pc, 32'h3000);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        chk("t1_ifpc2", if_id_pc, 32'h3008);

        // Two wait states before the ack.
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        chk("t2_ifpc", if_id_pc, 32'h3000);
        chk("t2_pc", pc, 32'h3004);

        // Ack during a 3-cycle stall: word waits in the buffer.
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 1, 1);
        cyc(0, 1, 1);
        cyc(0, 1, 1);
        chk("t3_frozen", if_id_pc, 32'h3000);
        cyc(0, 0, 1);
        chk("t3_ifpc", if_id_pc, 32'h3004);
        chk("t3_pc", pc, 32'h3008);

        // Taken branch with the delay slot delivered the same cycle.
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        tick(0, 0, 1, 1, 3'd1, 32'h3000, 32'hFFFF_FFFF, 32'd0, 26'd0);
        chk("t4_pc", pc, 32'h3000);
        chk("t4_slot", if_id_pc, 32'h3004);

        // Jump whose delay slot arrives two cycles later.
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        tick(0, 0, 0, 1, 3'd3, 32'h3008, 32'd0, 32'd0, 26'h0000C10);
        cyc(0, 0, 0);
        chk("t5_wait_pc", pc, 32'h300C);
        cyc(0, 0, 1);
        chk("t5_slot", if_id_pc, 32'h300C);
        chk("t5_pc", pc, 32'h3040);

        // Pending jr discarded by reset while holding a word.
        cyc(1, 0, 0);
        cyc(0, 0, 1);
        tick(0, 0, 0, 1, 3'd2, 32'h3000, 32'd0, 32'h4000, 26'd0);
        cyc(0, 1, 1);
        tick(0, 1, 0, 1, 3'd2, 32'h3000, 32'd0, 32'h4000, 26'd0);
        cyc(1, 1, 0);
        chk("t6_pc", pc, 32'h3000);
        chk("t6_valid", {31'd0, if_id_valid}, 32'd0);
        cyc(0, 0, 1);
        chk("t6_no_redir", pc, 32'h3004);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 3) == 0),
                 3'($urandom_range(0, 7)),
                 $urandom, $urandom, $urandom, 26'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
